// File: rtl/mld_7_4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mld_7_4_pkg
// Description : Shared constants and state encoding for the (7,3) cyclic-code
//               majority-logic decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package mld_7_4_pkg;

    localparam int C_N = 7;
    localparam int C_K = 3;

    // Orthogonal check-sum taps; every check also includes buf[6].
    localparam int C_A1_I0 = 3;
    localparam int C_A1_I1 = 4;
    localparam int C_A2_I0 = 1;
    localparam int C_A2_I1 = 5;
    localparam int C_A3_I0 = 0;
    localparam int C_A3_I1 = 2;

    typedef enum logic [0:0] {
        ST_LOAD   = 1'b0,
        ST_DECODE = 1'b1
    } state_t;

endpackage : mld_7_4_pkg
`default_nettype wire

// File: rtl/mld_maj3.sv
`default_nettype none
// ============================================================================
// Module      : mld_maj3
// Description : Three-input majority vote (true when two or more inputs set).
// Revision    : 1.0 - initial release
// ============================================================================
module mld_maj3 (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_maj
);

    assign o_maj = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule : mld_maj3
`default_nettype wire

// File: rtl/mld_7_4_decoder.sv
`default_nettype none
// ============================================================================
// Module      : mld_7_4_decoder
// Description : Serial one-step majority-logic decoder for the n=7 cyclic code
//               g(x)=1+x^2+x^3+x^4; loads 7 bits, then rotates and corrects.
//               Optional macro MLD_7_4_ERR_FLAG_EN adds port err_corrected.
// Revision    : 1.0 - initial release
// ============================================================================
module mld_7_4_decoder
    import mld_7_4_pkg::*;
#(
    parameter int N             = C_N,
    parameter int K             = C_K,
    parameter bit OUT_INFO_ONLY = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    input  logic in_bit,
    output logic in_ready,
    output logic out_valid,
    output logic out_bit,
    output logic out_last
`ifdef MLD_7_4_ERR_FLAG_EN
    ,
    output logic err_corrected
`endif
);

    if ((N != 7) || (K != 3)) begin : g_param_check
        $error("mld_7_4_decoder: N must be 7 and K must be 3");
    end

    localparam logic [2:0] C_LAST_IN  = 3'(N - 1);
    localparam logic [2:0] C_LAST_OUT = OUT_INFO_ONLY ? 3'(K - 1) : 3'(N - 1);

    state_t     r_state;
    state_t     w_state_next;
    logic [6:0] r_buf;
    logic [2:0] r_cnt;
    logic       r_out_valid;
    logic       r_out_bit;
    logic       r_out_last;

    logic       w_accept;
    logic       w_cnt_last;
    logic       w_a1;
    logic       w_a2;
    logic       w_a3;
    logic       w_fix;
    logic       w_cbit;
    logic       w_emit;
    logic       w_emit_last;

    assign in_ready    = (r_state == ST_LOAD);
    assign w_accept    = in_valid & in_ready;
    assign w_cnt_last  = (r_cnt == C_LAST_IN);

    assign w_a1 = r_buf[6] ^ r_buf[C_A1_I0] ^ r_buf[C_A1_I1];
    assign w_a2 = r_buf[6] ^ r_buf[C_A2_I0] ^ r_buf[C_A2_I1];
    assign w_a3 = r_buf[6] ^ r_buf[C_A3_I0] ^ r_buf[C_A3_I1];

    mld_maj3 u_maj3 (
        .i_a   (w_a1),
        .i_b   (w_a2),
        .i_c   (w_a3),
        .o_maj (w_fix)
    );

    assign w_cbit      = r_buf[6] ^ w_fix;
    assign w_emit      = (r_cnt <= C_LAST_OUT);
    assign w_emit_last = (r_cnt == C_LAST_OUT);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_LOAD:   if (w_accept && w_cnt_last) w_state_next = ST_DECODE;
            ST_DECODE: if (w_cnt_last)             w_state_next = ST_LOAD;
            default:                               w_state_next = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_LOAD;
            r_buf       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_bit   <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_out_valid <= 1'b0;
            r_out_bit   <= 1'b0;
            r_out_last  <= 1'b0;
            case (r_state)
                ST_LOAD: begin
                    if (w_accept) begin
                        r_buf <= {r_buf[5:0], in_bit};
                        r_cnt <= w_cnt_last ? 3'd0 : r_cnt + 3'd1;
                    end
                end
                ST_DECODE: begin
                    // Rotate so each position passes through buf[6] once, corrected on the way.
                    r_buf <= {r_buf[5:0], w_cbit};
                    r_cnt <= w_cnt_last ? 3'd0 : r_cnt + 3'd1;
                    if (w_emit) begin
                        r_out_valid <= 1'b1;
                        r_out_bit   <= w_cbit;
                        r_out_last  <= w_emit_last;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_bit   = r_out_bit;
    assign out_last  = r_out_last;

`ifdef MLD_7_4_ERR_FLAG_EN
    logic r_err_sticky;
    logic r_err_corrected;

    // Flag reports corrections seen up to and including the last emitted beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_sticky    <= 1'b0;
            r_err_corrected <= 1'b0;
        end else begin
            r_err_corrected <= 1'b0;
            if (r_state == ST_LOAD) begin
                if (w_accept && w_cnt_last) r_err_sticky <= 1'b0;
            end else begin
                r_err_sticky <= r_err_sticky | w_fix;
                if (w_emit && w_emit_last) r_err_corrected <= r_err_sticky | w_fix;
            end
        end
    end

    assign err_corrected = r_err_corrected;
`endif

endmodule : mld_7_4_decoder
`default_nettype wire

// File: tb/tb_mld_7_4_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mld_7_4_decoder
// Description : Directed self-checking bench; one info-only and one full-output
//               decoder share the same input stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mld_7_4_decoder;

    logic clk = 1'b0;
    logic reset;
    logic in_valid;
    logic in_bit;
    logic in_ready_a, out_valid_a, out_bit_a, out_last_a;
    logic in_ready_b, out_valid_b, out_bit_b, out_last_b;
`ifdef MLD_7_4_ERR_FLAG_EN
    logic err_a, err_b;
    logic err_seen_a;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Hand-computed codewords c6..c0 for info words 000..111.
    logic [6:0] code_tab [8] = '{7'b0000000, 7'b0011101, 7'b0100111, 7'b0111010,
                                 7'b1001110, 7'b1010011, 7'b1101001, 7'b1110100};

    logic [6:0] got_a, got_b;
    int beats_a, beats_b, last_a, last_b, ready_low;

    always #5 clk = ~clk;

    mld_7_4_decoder #(.OUT_INFO_ONLY(1'b1)) dut_info (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (in_ready_a),
        .out_valid (out_valid_a),
        .out_bit   (out_bit_a),
        .out_last  (out_last_a)
`ifdef MLD_7_4_ERR_FLAG_EN
        ,
        .err_corrected (err_a)
`endif
    );

    mld_7_4_decoder #(.OUT_INFO_ONLY(1'b0)) dut_full (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (in_ready_b),
        .out_valid (out_valid_b),
        .out_bit   (out_bit_b),
        .out_last  (out_last_b)
`ifdef MLD_7_4_ERR_FLAG_EN
        ,
        .err_corrected (err_b)
`endif
    );

    task automatic send_block(input logic [6:0] word, input int max_gap);
        for (int i = 6; i >= 0; i--) begin
            int gaps;
            gaps = $urandom_range(max_gap, 0);
            repeat (gaps) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_bit   = 1'($urandom_range(1, 0));
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_bit   = word[i];
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Starts on the negedge right after the 7th accept; ends 8 negedges later.
    task automatic collect(input bit noise);
        got_a = '0; got_b = '0;
        beats_a = 0; beats_b = 0; last_a = -1; last_b = -1; ready_low = 0;
`ifdef MLD_7_4_ERR_FLAG_EN
        err_seen_a = 1'b0;
`endif
        for (int k = 0; k < 9; k++) begin
            if (k > 0) @(negedge clk);
            if (!in_ready_a) ready_low++;
            if (out_valid_a) begin
                if (out_last_a) last_a = beats_a;
`ifdef MLD_7_4_ERR_FLAG_EN
                if (out_last_a) err_seen_a = err_a;
`endif
                got_a = {got_a[5:0], out_bit_a};
                beats_a++;
            end
            if (out_valid_b) begin
                if (out_last_b) last_b = beats_b;
                got_b = {got_b[5:0], out_bit_b};
                beats_b++;
            end
            in_valid = noise && (k < 7);
            in_bit   = 1'b1;
        end
        in_valid = 1'b0;
    endtask

    task automatic run_block(input logic [6:0] word, input int max_gap, input bit noise);
        send_block(word, max_gap);
        collect(noise);
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (in_ready_a !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready_a); end
        n_cmp++; if (out_valid_a !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid_a); end
        n_cmp++; if (out_bit_a !== 1'b0) begin n_bad++; $display("FAIL reset_out_bit got=%b exp=0", out_bit_a); end
        n_cmp++; if (out_last_a !== 1'b0) begin n_bad++; $display("FAIL reset_out_last got=%b exp=0", out_last_a); end
        reset = 1'b0;
    endtask

    task automatic test_clean();
        run_block(7'b1010011, 0, 1'b0);
        n_cmp++; if (beats_a != 3) begin n_bad++; $display("FAIL clean_beats got=%0d exp=3", beats_a); end
        n_cmp++; if (got_a[2:0] !== 3'b101) begin n_bad++; $display("FAIL clean_info got=%b exp=101", got_a[2:0]); end
        n_cmp++; if (last_a != 2) begin n_bad++; $display("FAIL clean_last got=%0d exp=2", last_a); end
`ifdef MLD_7_4_ERR_FLAG_EN
        n_cmp++; if (err_seen_a !== 1'b0) begin n_bad++; $display("FAIL clean_err got=%b exp=0", err_seen_a); end
`endif
    endtask

    task automatic test_r6_flip();
        run_block(7'b0010011, 0, 1'b0);
        n_cmp++; if (got_a[2:0] !== 3'b101) begin n_bad++; $display("FAIL r6flip_info got=%b exp=101", got_a[2:0]); end
        n_cmp++; if (last_a != 2) begin n_bad++; $display("FAIL r6flip_last got=%0d exp=2", last_a); end
`ifdef MLD_7_4_ERR_FLAG_EN
        n_cmp++; if (err_seen_a !== 1'b1) begin n_bad++; $display("FAIL r6flip_err got=%b exp=1", err_seen_a); end
`endif
    endtask

    task automatic test_single_errors();
        for (int info = 0; info < 8; info++) begin
            for (int pos = -1; pos < 7; pos++) begin
                logic [6:0] rx;
                logic [6:0] cw;
                cw = code_tab[info];
                rx = cw;
                if (pos >= 0) rx[pos] = ~rx[pos];
                run_block(rx, 1, 1'b0);
                n_cmp++;
                if (got_a[2:0] !== cw[6:4] || beats_a != 3) begin
                    n_bad++;
                    $display("FAIL single_err_info info=%0d pos=%0d got=%b beats=%0d exp=%b beats=3",
                             info, pos, got_a[2:0], beats_a, cw[6:4]);
                end
                n_cmp++;
                if (got_b !== cw || beats_b != 7) begin
                    n_bad++;
                    $display("FAIL single_err_full info=%0d pos=%0d got=%b beats=%0d exp=%b beats=7",
                             info, pos, got_b, beats_b, cw);
                end
            end
        end
    endtask

    task automatic test_full_output();
        run_block(7'b1000011, 0, 1'b0);
        n_cmp++; if (beats_b != 7) begin n_bad++; $display("FAIL full_beats got=%0d exp=7", beats_b); end
        n_cmp++; if (got_b !== 7'b1010011) begin n_bad++; $display("FAIL full_bits got=%b exp=1010011", got_b); end
        n_cmp++; if (last_b != 6) begin n_bad++; $display("FAIL full_last got=%0d exp=6", last_b); end
    endtask

    task automatic test_back_to_back();
        int seq [4] = '{3, 6, 0, 7};
        for (int b = 0; b < 4; b++) begin
            logic [6:0] cw;
            cw = code_tab[seq[b]];
            run_block(cw, 3, 1'b1);
            n_cmp++; if (got_a[2:0] !== cw[6:4]) begin n_bad++; $display("FAIL b2b_info blk=%0d got=%b exp=%b", b, got_a[2:0], cw[6:4]); end
            n_cmp++; if (ready_low != 7) begin n_bad++; $display("FAIL b2b_ready_low blk=%0d got=%0d exp=7", b, ready_low); end
            n_cmp++; if (in_ready_a !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_back blk=%0d got=%b exp=1", b, in_ready_a); end
        end
    endtask

    task automatic test_reset_mid_decode();
        int stray;
        send_block(7'b1010011, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        stray = 0;
        for (int k = 0; k < 12; k++) begin
            if (out_valid_a || out_valid_b) stray++;
            @(negedge clk);
        end
        n_cmp++; if (stray != 0) begin n_bad++; $display("FAIL rst_mid_stray got=%0d exp=0", stray); end
        n_cmp++; if (in_ready_a !== 1'b1) begin n_bad++; $display("FAIL rst_mid_ready got=%b exp=1", in_ready_a); end
        run_block(7'b0000000, 0, 1'b0);
        n_cmp++; if (got_a[2:0] !== 3'b000 || beats_a != 3) begin
            n_bad++; $display("FAIL rst_mid_next got=%b beats=%0d exp=000 beats=3", got_a[2:0], beats_a);
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_r6_flip();
        test_single_errors();
        test_full_output();
        test_back_to_back();
        test_reset_mid_decode();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_mld_7_4_decoder
`default_nettype wire
